// File: rtl/serial_adder.sv
// serial_adder: DIGIT-bits-per-cycle LSB-first adder with valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             co
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $fatal(1, "serial_adder: DIGIT must divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic carry, last;
  logic [DIGIT:0] slice;
  assign slice = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
  assign last = cnt == CW'(STEPS - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // carry only changes at accept or while busy, so it doubles as the held carry-out
  assign co = carry;
  always_comb begin
    next = state;
    next = (state == IDLE && in_valid) ? BUSY :
           (state == BUSY && last) ? DONE :
           (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : next;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= ci;
      cnt   <= '0;
    end else if (state == BUSY) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      s     <= WIDTH'({slice[DIGIT-1:0], s} >> DIGIT);
      carry <= slice[DIGIT];
      cnt   <= cnt + CW'(1);
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  // carry into the top bit recovered from the top slice bit: d ^ a ^ b
  always_ff @(posedge clk) begin
    if (!rst_n) ovf <= 1'b0;
    else if (state == BUSY && last)
      ovf <= slice[DIGIT] ^ slice[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
  end
`endif
endmodule
